// File: rtl/fpu_op_sequencer.sv
// Sequencer between a single requester and a multi-cycle FP datapath: issue, wait for done, hold response.
// Define FPU_SEQ_TIMEOUT_EN to add a WAIT watchdog that aborts after TIMEOUT_CYC cycles.
module fpu_op_sequencer #(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic              unit_start,
  output logic [1:0]        unit_sel,
  output logic [DATA_W-1:0] unit_a,
  output logic [DATA_W-1:0] unit_b,
  input  logic              done_add_sub,
  input  logic              done_div,
  input  logic [DATA_W-1:0] unit_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_timeout,
  output logic              busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_e;

  state_e              state_q;
  logic                req_ready_q;
  logic                busy_q;
  logic                unit_start_q;
  logic                rsp_valid_q;
  logic [1:0]          sel_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic                qual_done;
  logic                timeout_hit;

  // Only the flag belonging to the selected unit may end the wait.
  assign qual_done = (sel_q == 2'b11) ? done_div : done_add_sub;

`ifdef FPU_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

  logic [CNT_W-1:0] tmo_cnt_q;
  logic             rsp_timeout_q;

  assign timeout_hit = (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign rsp_timeout = rsp_timeout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q     <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      if (state_q == ST_ISSUE)
        tmo_cnt_q <= '0;
      else if (state_q == ST_WAIT && !qual_done && !timeout_hit)
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      // A done arriving on the expiry cycle still counts as a real result.
      if (state_q == ST_WAIT) begin
        if (qual_done)
          rsp_timeout_q <= 1'b0;
        else if (timeout_hit)
          rsp_timeout_q <= 1'b1;
      end
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo  = (TIMEOUT_CYC > 0);
  assign timeout_hit = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      unit_start_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      sel_q        <= 2'b00;
      a_q          <= '0;
      b_q          <= '0;
      rsp_data_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            sel_q        <= req_op;
            a_q          <= req_a;
            b_q          <= req_b;
            unit_start_q <= 1'b1;
            req_ready_q  <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          unit_start_q <= 1'b0;
          state_q      <= ST_WAIT;
        end
        ST_WAIT: begin
          if (qual_done) begin
            rsp_data_q  <= unit_result;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else if (timeout_hit) begin
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          req_ready_q  <= 1'b1;
          busy_q       <= 1'b0;
          unit_start_q <= 1'b0;
          rsp_valid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign busy       = busy_q;
  assign unit_start = unit_start_q;
  assign unit_sel   = sel_q;
  assign unit_a     = a_q;
  assign unit_b     = b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Scoreboard bench for fpu_op_sequencer; the requester and the FP datapath are both played by the bench.
module tb_fpu_op_sequencer;

  localparam int DATA_W = 32;
`ifdef FPU_SEQ_TIMEOUT_EN
  localparam int TB_TMO       = 8;
  localparam int DIV_DONE_CYC = 6;
`else
  localparam int TB_TMO       = 64;
  localparam int DIV_DONE_CYC = 20;
`endif

  typedef struct packed {
    logic              tmo;
    logic [DATA_W-1:0] data;
  } rsp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready;
  logic [1:0]        req_op;
  logic [DATA_W-1:0] req_a, req_b;
  logic              unit_start;
  logic [1:0]        unit_sel;
  logic [DATA_W-1:0] unit_a, unit_b;
  logic              done_add_sub, done_div;
  logic [DATA_W-1:0] unit_result;
  logic              rsp_valid, rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_timeout;
  logic              busy;

  rsp_t sb[$];
  rsp_t exp_r;
  int   n_vec = 0;
  int   n_err = 0;

  fpu_op_sequencer #(.DATA_W(DATA_W), .TIMEOUT_CYC(TB_TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .unit_start(unit_start), .unit_sel(unit_sel), .unit_a(unit_a), .unit_b(unit_b),
    .done_add_sub(done_add_sub), .done_div(done_div), .unit_result(unit_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [1:0] op, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_a = '0; req_b = '0;
    done_add_sub = 1'b0; done_div = 1'b0; unit_result = '0; rsp_ready = 1'b0;
    tick(); tick();
    n_vec++;
    if ({unit_start, rsp_valid, rsp_timeout, busy, unit_sel} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctrl got start=%b vld=%b tmo=%b busy=%b sel=%b want all 0",
               unit_start, rsp_valid, rsp_timeout, busy, unit_sel);
    end
    n_vec++;
    if ({rsp_data, unit_a, unit_b} !== '0) begin
      n_err++;
      $display("FAIL reset_data got data=%h a=%h b=%h want 0", rsp_data, unit_a, unit_b);
    end
    rst = 1'b0;
    tick();
    n_vec++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release got ready=%b busy=%b want 1/0", req_ready, busy);
    end
  endtask

  task automatic test_add();
    drive_req(2'b00, 32'h3F800000, 32'h40000000);
    tick();
    req_valid = 1'b0;
    n_vec++;
    if (unit_start !== 1'b1 || unit_sel !== 2'b00 || unit_a !== 32'h3F800000 ||
        unit_b !== 32'h40000000 || req_ready !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL add_issue got start=%b sel=%b a=%h b=%h rdy=%b busy=%b want 1 00 3f800000 40000000 0 1",
               unit_start, unit_sel, unit_a, unit_b, req_ready, busy);
    end
    done_add_sub = 1'b1; unit_result = 32'hBAD0BAD0;
    tick();
    n_vec++;
    if (unit_start !== 1'b0 || rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL add_wait1 got start=%b vld=%b want 0/0", unit_start, rsp_valid);
    end
    unit_result = 32'h40400000;
    sb.push_back('{tmo: 1'b0, data: 32'h40400000});
    tick();
    done_add_sub = 1'b0;
    n_vec++;
    if (rsp_valid !== 1'b1 || sb.size() == 0) begin
      n_err++;
      $display("FAIL add_latency got vld=%b want 1 on 3rd cycle after accept", rsp_valid);
    end else begin
      exp_r = sb.pop_front();
      if (rsp_data !== exp_r.data || rsp_timeout !== exp_r.tmo) begin
        n_err++;
        $display("FAIL add_rsp got data=%h tmo=%b want %h/%b", rsp_data, rsp_timeout, exp_r.data, exp_r.tmo);
      end
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_vec++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL add_release got vld=%b rdy=%b busy=%b want 0 1 0", rsp_valid, req_ready, busy);
    end
  endtask

  task automatic test_div_spurious();
    logic [DATA_W-1:0] a, b, r;
    a = $urandom; b = $urandom; r = $urandom;
    drive_req(2'b11, a, b);
    tick();
    req_valid = 1'b0;
    tick();
    for (int c = 1; c < DIV_DONE_CYC; c++) begin
      done_add_sub = (c == 2);
      unit_result  = ~r;
      tick();
      n_vec++;
      if (rsp_valid !== 1'b0 || unit_sel !== 2'b11 || unit_a !== a || unit_b !== b) begin
        n_err++;
        $display("FAIL div_hold cyc %0d got vld=%b sel=%b a=%h want 0 11 %h", c, rsp_valid, unit_sel, unit_a, a);
      end
    end
    done_add_sub = 1'b0; done_div = 1'b1; unit_result = r;
    sb.push_back('{tmo: 1'b0, data: r});
    tick();
    done_div = 1'b0;
    n_vec++;
    if (rsp_valid !== 1'b1 || sb.size() == 0) begin
      n_err++;
      $display("FAIL div_done got vld=%b want 1", rsp_valid);
    end else begin
      exp_r = sb.pop_front();
      if (rsp_data !== exp_r.data || rsp_timeout !== exp_r.tmo) begin
        n_err++;
        $display("FAIL div_rsp got data=%h tmo=%b want %h/%b", rsp_data, rsp_timeout, exp_r.data, exp_r.tmo);
      end
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] a2, b2, r, r2;
    a2 = $urandom; b2 = $urandom; r = $urandom; r2 = $urandom;
    drive_req(2'b01, $urandom, $urandom);
    tick();
    req_valid = 1'b0;
    tick();
    done_add_sub = 1'b1; unit_result = r;
    sb.push_back('{tmo: 1'b0, data: r});
    tick();
    done_add_sub = 1'b0;
    exp_r = sb.pop_front();
    drive_req(2'b10, a2, b2);
    for (int i = 0; i < 10; i++) begin
      done_add_sub = i[0]; done_div = ~i[0]; unit_result = $urandom;
      tick();
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp_r.data || rsp_timeout !== exp_r.tmo ||
          req_ready !== 1'b0 || unit_sel !== 2'b01) begin
        n_err++;
        $display("FAIL bp_stall %0d got vld=%b data=%h tmo=%b rdy=%b sel=%b want 1 %h %b 0 01",
                 i, rsp_valid, rsp_data, rsp_timeout, req_ready, unit_sel, exp_r.data, exp_r.tmo);
      end
    end
    done_add_sub = 1'b0; done_div = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_vec++;
    if (req_ready !== 1'b1 || unit_start !== 1'b0 || rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_idle got rdy=%b start=%b vld=%b want 1 0 0", req_ready, unit_start, rsp_valid);
    end
    tick();
    req_valid = 1'b0;
    n_vec++;
    if (unit_start !== 1'b1 || unit_sel !== 2'b10 || unit_a !== a2 || unit_b !== b2) begin
      n_err++;
      $display("FAIL bp_accept got start=%b sel=%b a=%h b=%h want 1 10 %h %h", unit_start, unit_sel, unit_a, unit_b, a2, b2);
    end
    tick();
    done_add_sub = 1'b1; unit_result = r2;
    sb.push_back('{tmo: 1'b0, data: r2});
    tick();
    done_add_sub = 1'b0;
    n_vec++;
    if (rsp_valid !== 1'b1 || sb.size() == 0) begin
      n_err++;
      $display("FAIL bp_second got vld=%b want 1", rsp_valid);
    end else begin
      exp_r = sb.pop_front();
      if (rsp_data !== exp_r.data || rsp_timeout !== exp_r.tmo) begin
        n_err++;
        $display("FAIL bp_second_rsp got data=%h tmo=%b want %h/%b", rsp_data, rsp_timeout, exp_r.data, exp_r.tmo);
      end
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

`ifdef FPU_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    logic [DATA_W-1:0] r;
    for (int pass = 0; pass < 2; pass++) begin
      r = $urandom | 32'h1;
      drive_req(2'b10, $urandom, $urandom);
      tick();
      req_valid = 1'b0;
      tick();
      for (int c = 1; c < TB_TMO; c++) begin
        tick();
        n_vec++;
        if (rsp_valid !== 1'b0) begin
          n_err++;
          $display("FAIL tmo_early pass %0d cyc %0d got vld=%b want 0", pass, c, rsp_valid);
        end
      end
      if (pass == 1) begin
        done_add_sub = 1'b1; unit_result = r;
        sb.push_back('{tmo: 1'b0, data: r});
      end else begin
        sb.push_back('{tmo: 1'b1, data: '0});
      end
      tick();
      done_add_sub = 1'b0;
      n_vec++;
      if (rsp_valid !== 1'b1 || sb.size() == 0) begin
        n_err++;
        $display("FAIL tmo_resp pass %0d got vld=%b want 1", pass, rsp_valid);
      end else begin
        exp_r = sb.pop_front();
        if (rsp_data !== exp_r.data || rsp_timeout !== exp_r.tmo) begin
          n_err++;
          $display("FAIL tmo_rsp pass %0d got data=%h tmo=%b want %h/%b", pass, rsp_data, rsp_timeout, exp_r.data, exp_r.tmo);
        end
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
    end
  endtask
`else
  task automatic test_no_timeout();
    logic [DATA_W-1:0] r;
    logic              held;
    r = $urandom; held = 1'b1;
    drive_req(2'b10, $urandom, $urandom);
    tick();
    req_valid = 1'b0;
    tick();
    for (int c = 0; c < 100; c++) begin
      tick();
      if (rsp_valid !== 1'b0 || busy !== 1'b1 || rsp_timeout !== 1'b0) held = 1'b0;
    end
    n_vec++;
    if (held !== 1'b1) begin
      n_err++;
      $display("FAIL notmo_hold got held=%b want 1", held);
    end
    done_add_sub = 1'b1; unit_result = r;
    sb.push_back('{tmo: 1'b0, data: r});
    tick();
    done_add_sub = 1'b0;
    n_vec++;
    if (rsp_valid !== 1'b1 || sb.size() == 0) begin
      n_err++;
      $display("FAIL notmo_resp got vld=%b want 1", rsp_valid);
    end else begin
      exp_r = sb.pop_front();
      if (rsp_data !== exp_r.data || rsp_timeout !== exp_r.tmo) begin
        n_err++;
        $display("FAIL notmo_rsp got data=%h tmo=%b want %h/%b", rsp_data, rsp_timeout, exp_r.data, exp_r.tmo);
      end
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask
`endif

  task automatic test_reset_mid_wait();
    drive_req(2'b11, $urandom | 32'h1, $urandom | 32'h1);
    tick();
    req_valid = 1'b0;
    tick();
    repeat (4) tick();
    rst = 1'b1;
    #1;
    n_vec++;
    if ({unit_start, rsp_valid, rsp_timeout, busy, unit_sel} !== 6'b0 || req_ready !== 1'b1 ||
        {rsp_data, unit_a, unit_b} !== '0) begin
      n_err++;
      $display("FAIL rst_wait got start=%b vld=%b tmo=%b busy=%b sel=%b rdy=%b data=%h a=%h b=%h want zeros rdy=1",
               unit_start, rsp_valid, rsp_timeout, busy, unit_sel, req_ready, rsp_data, unit_a, unit_b);
    end
    tick();
    rst = 1'b0;
    done_div = 1'b1; unit_result = 32'h12345678;
    tick(); tick();
    done_div = 1'b0;
    n_vec++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_data !== '0 || req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_late_done got vld=%b busy=%b data=%h rdy=%b want 0 0 0 1", rsp_valid, busy, rsp_data, req_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]        op;
    logic [DATA_W-1:0] a, b, r;
    for (int k = 0; k < 6; k++) begin
      op = 2'(k % 4); a = $urandom; b = $urandom; r = $urandom;
      drive_req(op, a, b);
      n_vec++;
      if (req_ready !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_ready %0d got %b want 1", k, req_ready);
      end
      tick();
      n_vec++;
      if (unit_start !== 1'b1 || unit_sel !== op || unit_a !== a || unit_b !== b) begin
        n_err++;
        $display("FAIL b2b_accept %0d got start=%b sel=%b a=%h b=%h want 1 %b %h %h", k, unit_start, unit_sel, unit_a, unit_b, op, a, b);
      end
      tick();
      if (op == 2'b11) done_add_sub = 1'b1; else done_div = 1'b1;
      unit_result = ~r;
      tick();
      done_add_sub = 1'b0; done_div = 1'b0;
      if (op == 2'b11) done_div = 1'b1; else done_add_sub = 1'b1;
      unit_result = r;
      sb.push_back('{tmo: 1'b0, data: r});
      tick();
      done_add_sub = 1'b0; done_div = 1'b0;
      n_vec++;
      if (rsp_valid !== 1'b1 || sb.size() == 0) begin
        n_err++;
        $display("FAIL b2b_vld %0d got %b want 1", k, rsp_valid);
      end else begin
        exp_r = sb.pop_front();
        if (rsp_data !== exp_r.data || rsp_timeout !== exp_r.tmo) begin
          n_err++;
          $display("FAIL b2b_rsp %0d got data=%h tmo=%b want %h/%b", k, rsp_data, rsp_timeout, exp_r.data, exp_r.tmo);
        end
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      n_vec++;
      if (unit_start !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
        n_err++;
        $display("FAIL b2b_idle %0d got start=%b busy=%b vld=%b want 0 0 0", k, unit_start, busy, rsp_valid);
      end
    end
    req_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_div_spurious();
    test_backpressure();
`ifdef FPU_SEQ_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid_wait();
    test_back_to_back();
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain got %0d leftover want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
